// File: rtl/float_add_ctl_if.sv
// Handshake and datapath bundle for float_add_ctl.
//   slave  : the controller side (accepts operands, drives adder inputs and results)
//   master : the client side (offers operands, models the adder, consumes results)
// Signals:
//   in_valid/in_ready/in_a/in_b/in_tag : operand-pair handshake
//   hold                               : suppresses issue to the adder
//   add_v1/add_v2/add_vres             : adder operand and result buses
//   res_valid/res/res_tag/res_special  : tagged result strobe
interface float_add_ctl_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             hold;
  logic [31:0]      add_v1;
  logic [31:0]      add_v2;
  logic [31:0]      add_vres;
  logic             res_valid;
  logic [31:0]      res;
  logic [TAG_W-1:0] res_tag;
  logic             res_special;

  modport slave (
    input  in_valid, in_a, in_b, in_tag, hold, add_vres,
    output in_ready, add_v1, add_v2, res_valid, res, res_tag, res_special
  );

  modport master (
    output in_valid, in_a, in_b, in_tag, hold, add_vres,
    input  in_ready, add_v1, add_v2, res_valid, res, res_tag, res_special
  );
endinterface

// File: rtl/float_add_ctl.sv
// Issue and result-merge controller around a pipelined float
// magnitude-difference adder. Operand pairs are buffered in a small FIFO,
// issued one per cycle to the adder, and tracked through a delay line
// matched to the adder latency. Operand classes the adder cannot handle
// (inf/NaN, equal magnitudes, zero/denormal exponents) are resolved at issue
// and substituted at the output.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : float_add_ctl_if.slave (operand handshake, adder buses, results)
module float_add_ctl #(
  parameter int LAT   = 6,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic            clk,
  input logic            rst,
  float_add_ctl_if.slave bus
);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int NST = LAT + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // operand FIFO
  logic [31:0]      mem_a_q   [DEPTH];
  logic [31:0]      mem_b_q   [DEPTH];
  logic [TAG_W-1:0] mem_tag_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             in_ready_q;
  logic             push, pop;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = (count_q != '0) & ~bus.hold;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // in_ready is registered from the next count so it can never admit a
  // push into a full FIFO, and a pop only raises it on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q    <= count_d;
      in_ready_q <= (count_d != FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q]   <= bus.in_a;
      mem_b_q[wr_ptr_q]   <= bus.in_b;
      mem_tag_q[wr_ptr_q] <= bus.in_tag;
    end
  end

  // head-of-FIFO classification; first matching rule wins
  logic [31:0]      head_a, head_b;
  logic [TAG_W-1:0] head_tag;
  logic             head_sp;
  logic [31:0]      head_sv;

  always_comb begin
    head_a   = mem_a_q[rd_ptr_q];
    head_b   = mem_b_q[rd_ptr_q];
    head_tag = mem_tag_q[rd_ptr_q];
    head_sp  = 1'b1;
    head_sv  = '0;
    if (head_a[30:23] == 8'hFF || head_b[30:23] == 8'hFF) begin
      head_sv = 32'h7FC0_0000;
    end else if (head_a[30:0] == head_b[30:0]) begin
      head_sv = 32'h0000_0000;
    end else if (head_a[30:23] == 8'h00) begin
      head_sv = {1'b0, head_b[30:0]};
    end else if (head_b[30:23] == 8'h00) begin
      head_sv = {1'b0, head_a[30:0]};
    end else begin
      head_sp = 1'b0;
    end
  end

  // adder operand registers: hold last value when nothing is issued
  logic [31:0] v1_q, v2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= '0;
      v2_q <= '0;
    end else if (pop) begin
      v1_q <= head_a;
      v2_q <= head_b;
    end
  end

  assign bus.add_v1 = v1_q;
  assign bus.add_v2 = v2_q;

  // Delay line: stage 0 lines up with add_v1/add_v2, the last stage with the
  // matching add_vres. It never stalls because the adder cannot.
  logic [NST-1:0]   dl_v_q;
  logic [NST-1:0]   dl_sp_q;
  logic [TAG_W-1:0] dl_tag_q [NST];
  logic [31:0]      dl_sv_q  [NST];

  always_ff @(posedge clk) begin
    if (rst) dl_v_q <= '0;
    else     dl_v_q <= {dl_v_q[NST-2:0], pop};
  end

  // payload is qualified by dl_v_q, so it needs no reset
  always_ff @(posedge clk) begin
    dl_sp_q     <= {dl_sp_q[NST-2:0], head_sp};
    dl_tag_q[0] <= head_tag;
    dl_sv_q[0]  <= head_sv;
    for (int k = 1; k < NST; k++) begin
      dl_tag_q[k] <= dl_tag_q[k-1];
      dl_sv_q[k]  <= dl_sv_q[k-1];
    end
  end

  // result register: payload holds its last value between strobes
  logic             res_valid_q;
  logic [31:0]      res_q;
  logic [TAG_W-1:0] res_tag_q;
  logic             res_sp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_q       <= '0;
      res_tag_q   <= '0;
      res_sp_q    <= 1'b0;
    end else begin
      res_valid_q <= dl_v_q[NST-1];
      if (dl_v_q[NST-1]) begin
        res_q     <= dl_sp_q[NST-1] ? dl_sv_q[NST-1] : bus.add_vres;
        res_tag_q <= dl_tag_q[NST-1];
        res_sp_q  <= dl_sp_q[NST-1];
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res         = res_q;
  assign bus.res_tag     = res_tag_q;
  assign bus.res_special = res_sp_q;
endmodule

// File: tb/tb_float_add_ctl.sv
// Scoreboard bench for float_add_ctl: models the external pipelined adder,
// pushes the expected result on every accepted pair and compares on every
// result strobe.
module tb_float_add_ctl;
  localparam int LAT   = 6;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  float_add_ctl_if #(.TAG_W(TAG_W)) bus ();

  float_add_ctl #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             sp;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int   res_cyc_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   ncyc     = 0;
  int   n_res    = 0;
  int   last_lat = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  // reference |(|a| - |b|)| for normal operands, via double precision
  function automatic logic [31:0] magdiff(input logic [31:0] a, input logic [31:0] b);
    real         ra, rb, d;
    logic [10:0] ea11, eb11, e11;
    logic [63:0] bits;
    if (a[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'h00 || b[30:23] == 8'hFF)
      return 32'hDEAD_BEEF;
    ea11 = 11'(a[30:23]) + 11'd896;
    eb11 = 11'(b[30:23]) + 11'd896;
    ra = $bitstoreal({1'b0, ea11, a[22:0], 29'd0});
    rb = $bitstoreal({1'b0, eb11, b[22:0], 29'd0});
    d = ra - rb;
    if (d < 0.0) d = -d;
    bits = $realtobits(d);
    if (bits[62:0] == 63'd0) return 32'h0;
    e11 = bits[62:52] - 11'd896;
    return {1'b0, e11[7:0], bits[51:29]};
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [TAG_W-1:0] tag, input int acc);
    exp_t e;
    e.tag = tag;
    e.acc = acc;
    e.sp  = 1'b1;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) e.res = 32'h7FC0_0000;
    else if (a[30:0] == b[30:0])                e.res = 32'h0;
    else if (a[30:23] == 8'h00)                 e.res = {1'b0, b[30:0]};
    else if (b[30:23] == 8'h00)                 e.res = {1'b0, a[30:0]};
    else begin
      e.sp  = 1'b0;
      e.res = magdiff(a, b);
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_norm();
    logic [31:0] r;
    r = $urandom;
    r[30:23] = 8'($urandom_range(100, 154));
    return r;
  endfunction

  // external adder: LAT register stages from add_v1/add_v2 to add_vres
  logic [31:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= magdiff(bus.add_v1, bus.add_v2);
    for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign bus.add_vres = apipe[LAT-1];

  // monitor / scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.res_valid) begin
        n_res++;
        res_cyc_q.push_back(ncyc);
        check_val("res_expected", 64'(sb.size() > 0), 64'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          last_lat = ncyc - e.acc;
          check_val("res", bus.res, e.res);
          check_val("res_tag", bus.res_tag, e.tag);
          check_val("res_special", bus.res_special, e.sp);
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back(model(bus.in_a, bus.in_b, bus.in_tag, ncyc));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // offer a pair and return just after the edge that accepts it
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
    bit got;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = bus.in_ready;
    end
    check_val("send_accept", 64'(got), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    check_val("drain_empty", 64'(sb.size()), 64'(0));
    step(LAT + 4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_in_ready"},    bus.in_ready, 1'b0);
    check_val({tag, "_res_valid"},   bus.res_valid, 1'b0);
    check_val({tag, "_res"},         bus.res, 32'h0);
    check_val({tag, "_res_tag"},     bus.res_tag, '0);
    check_val({tag, "_res_special"}, bus.res_special, 1'b0);
    check_val({tag, "_add_v1"},      bus.add_v1, 32'h0);
    check_val({tag, "_add_v2"},      bus.add_v2, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    logic [TAG_W-1:0] tg;
    bit heavy;

    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_tag   = '0;
    bus.hold     = 1'b0;
    rst          = 1'b1;
    step(3);
    check_reset_outputs("rst");
    rst = 1'b0;
    step(1);
    check_val("in_ready_after_rst", bus.in_ready, 1'b1);

    // single pair: latency and single strobe
    n0 = n_res;
    send(32'h4040_0000, 32'h3F80_0000, 4'd5);
    idle();
    drain();
    check_val("lat", 64'(last_lat), 64'(LAT + 3));
    check_val("single_pulse", 64'(n_res - n0), 64'(1));
    check_val("res_3m1", bus.res, 32'h4000_0000);
    check_val("res_3m1_tag", bus.res_tag, 4'd5);

    // bypassed operand classes, back to back
    send(32'h0000_0000, 32'hC0A0_0000, 4'd1);
    send(32'h3F80_0000, 32'hBF80_0000, 4'd2);
    send(32'h7F80_0000, 32'h3F80_0000, 4'd3);
    idle();
    drain();
    check_val("last_special_res", bus.res, 32'h7FC0_0000);
    check_val("last_special_flag", bus.res_special, 1'b1);

    // hold: FIFO fills to DEPTH, fifth pair waits
    bus.hold = 1'b1;
    res_cyc_q.delete();
    for (int i = 1; i <= 4; i++) send(rnd_norm(), rnd_norm(), 4'(i));
    bus.in_valid = 1'b1;
    bus.in_a     = rnd_norm();
    bus.in_b     = rnd_norm();
    bus.in_tag   = 4'd5;
    repeat (3) @(negedge clk);
    check_val("hold_full_in_ready", bus.in_ready, 1'b0);
    check_val("hold_pending", 64'(sb.size()), 64'(4));
    @(posedge clk);
    #1;
    bus.hold = 1'b0;
    send(bus.in_a, bus.in_b, 4'd5);
    idle();
    drain();
    check_val("hold_res_count", 64'(res_cyc_q.size()), 64'(5));
    if (res_cyc_q.size() >= 4)
      check_val("hold_first4_consec", 64'(res_cyc_q[3] - res_cyc_q[0]), 64'(3));

    // sustained throughput with random normal operands
    res_cyc_q.delete();
    for (int i = 0; i < 100; i++) send(rnd_norm(), rnd_norm(), 4'(i));
    idle();
    drain();
    check_val("stream_count", 64'(res_cyc_q.size()), 64'(100));
    if (res_cyc_q.size() == 100)
      check_val("stream_back_to_back", 64'(res_cyc_q[99] - res_cyc_q[0]), 64'(99));

    // random hold toggling with mixed push/pop around full and empty
    tg = '0;
    heavy = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i % 20 == 0) heavy = ~heavy;
      bus.hold     = heavy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_a     = ($urandom_range(0, 7) == 0) ? 32'h0 : rnd_norm();
      bus.in_b     = rnd_norm();
      bus.in_tag   = tg;
      tg           = tg + 1'b1;
      step(1);
    end
    bus.hold = 1'b0;
    idle();
    drain();

    // reset with pairs in flight: none of them may come out
    send(rnd_norm(), rnd_norm(), 4'd7);
    send(rnd_norm(), rnd_norm(), 4'd8);
    send(rnd_norm(), rnd_norm(), 4'd9);
    idle();
    step(1);
    rst = 1'b1;
    n0 = n_res;
    step(1);
    check_reset_outputs("midrst");
    rst = 1'b0;
    step(20);
    check_val("no_res_after_rst", 64'(n_res - n0), 64'(0));
    send(32'h4040_0000, 32'h3F80_0000, 4'd12);
    idle();
    drain();
    check_val("post_rst_count", 64'(n_res - n0), 64'(1));
    check_val("post_rst_res", bus.res, 32'h4000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
